// File: rtl/timer_display_scan.sv
// timer_display_scan
// Drives a 3-digit, common-anode, time-multiplexed 7-segment display (M:SS) from the
// timer digit buses. Digits are captured into shadows once per scan frame so that a
// frame never mixes old and new values. The start of each digit slot is blanked to
// suppress ghosting. While paused, the whole display blinks with a half-period of
// BLINK_FRAMES frames. All outputs are registered and lag the scan state by one cycle.
module timer_display_scan #(
   parameter int SCAN_DIV     = 50000,  // clk cycles per digit slot (>=2)
   parameter int BLANK_CYCLES = 64,     // blanked cycles at start of each slot (< SCAN_DIV)
   parameter int BLINK_FRAMES = 100     // frames per blink half-period (>=1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] seconds0,
   input  logic [5:0] seconds1,
   input  logic [5:0] minutes0,
   input  logic       paused,
   output logic [2:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
   localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      SLOT_S0 = 2'd0,
      SLOT_S1 = 2'd1,
      SLOT_M0 = 2'd2
   } slot_t;

   slot_t           r_slot;
   slot_t           w_slot_nxt;
   logic [PW-1:0]   r_p;
   logic [FW-1:0]   r_frame;
   logic            r_phase_on;
   logic [5:0]      r_sh_s0;
   logic [5:0]      r_sh_s1;
   logic [5:0]      r_sh_m0;
   logic [2:0]      r_an;
   logic [6:0]      r_seg;
   logic            r_dp;

   logic            w_p_wrap;
   logic            w_frame_end;
   logic            w_blank;
   logic            w_off;
   logic [5:0]      w_digit;
   logic [2:0]      w_an_lit;
   logic            w_dp_lit;

   // Shadow value -> active-low {g,f,e,d,c,b,a}; every bit of the value is significant.
   function automatic logic [6:0] seg_decode(input logic [5:0] v);
      logic [6:0] s;
      case (v)
         6'd0:    s = 7'h40;
         6'd1:    s = 7'h79;
         6'd2:    s = 7'h24;
         6'd3:    s = 7'h30;
         6'd4:    s = 7'h19;
         6'd5:    s = 7'h12;
         6'd6:    s = 7'h02;
         6'd7:    s = 7'h78;
         6'd8:    s = 7'h00;
         6'd9:    s = 7'h10;
         default: s = 7'h3F;  // out-of-range digit shown as a dash
      endcase
      return s;
   endfunction

   assign w_p_wrap    = (r_p == P_LAST);
   assign w_frame_end = w_p_wrap && (r_slot == SLOT_M0);
   assign w_blank     = (r_p < P_BLANK);
   // Blink-off is qualified with paused so un-pausing lights the display on the next edge.
   assign w_off       = paused && !r_phase_on;

   // Prescaler: counts cycles within the current digit slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_p <= '0;
      end else if (w_p_wrap) begin
         r_p <= '0;
      end else begin
         r_p <= r_p + 1'b1;
      end
   end

   // Slot state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_slot <= SLOT_S0;
      end else begin
         r_slot <= w_slot_nxt;
      end
   end

   // Slot sequencing s0 -> s1 -> m0 -> s0, plus per-slot digit and anode selection.
   always_comb begin
      w_slot_nxt = r_slot;
      w_digit    = r_sh_s0;
      w_an_lit   = 3'b111;
      w_dp_lit   = 1'b1;
      case (r_slot)
         SLOT_S0: begin
            if (w_p_wrap) w_slot_nxt = SLOT_S1;
            w_digit  = r_sh_s0;
            w_an_lit = 3'b110;
         end
         SLOT_S1: begin
            if (w_p_wrap) w_slot_nxt = SLOT_M0;
            w_digit  = r_sh_s1;
            w_an_lit = 3'b101;
         end
         SLOT_M0: begin
            if (w_p_wrap) w_slot_nxt = SLOT_S0;
            w_digit  = r_sh_m0;
            w_an_lit = 3'b011;
            w_dp_lit = 1'b0;  // M.SS separator
         end
         default: begin
            w_slot_nxt = SLOT_S0;
         end
      endcase
   end

   // Digit shadows: reloaded only at frame end so a frame is always self-consistent.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sh_s0 <= '0;
         r_sh_s1 <= '0;
         r_sh_m0 <= '0;
      end else if (w_frame_end) begin
         r_sh_s0 <= seconds0;
         r_sh_s1 <= seconds1;
         r_sh_m0 <= minutes0;
      end
   end

   // Blink timing: frame counter and phase run only while paused, otherwise held at ON.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame    <= '0;
         r_phase_on <= 1'b1;
      end else if (!paused) begin
         r_frame    <= '0;
         r_phase_on <= 1'b1;
      end else if (w_frame_end) begin
         if (r_frame == F_LAST) begin
            r_frame    <= '0;
            r_phase_on <= !r_phase_on;
         end else begin
            r_frame <= r_frame + 1'b1;
         end
      end
   end

   // Registered display outputs, derived from the scan state of the current cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_an  <= 3'b111;
         r_seg <= 7'h7F;
         r_dp  <= 1'b1;
      end else if (w_blank || w_off) begin
         r_an  <= 3'b111;
         r_seg <= 7'h7F;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an_lit;
         r_seg <= seg_decode(w_digit);
         r_dp  <= w_dp_lit;
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
   assign dp  = r_dp;

endmodule

// File: tb/tb_timer_display_scan.sv
// tb_timer_display_scan
// Table-driven frame checks for the display scanner, with hand-written sequences for
// mid-frame un-pause and mid-slot reset, plus a per-cycle anode exclusivity monitor.
module tb_timer_display_scan;

   logic       clk;
   logic       reset;
   logic [5:0] seconds0;
   logic [5:0] seconds1;
   logic [5:0] minutes0;
   logic       paused;
   logic [2:0] an;
   logic [6:0] seg;
   logic       dp;

   int checks;
   int errors;
   int inv_checks;
   int inv_errors;
   logic [2:0] prev_an;

   timer_display_scan #(
      .SCAN_DIV     (4),
      .BLANK_CYCLES (1),
      .BLINK_FRAMES (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .seconds0 (seconds0),
      .seconds1 (seconds1),
      .minutes0 (minutes0),
      .paused   (paused),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One frame: paused at frame start, inputs and paused_mid applied mid slot 1,
   // lit_a/lit_b = expected lit state before/after the mid-frame change,
   // e0/e1/e2 = expected seg for slots s0/s1/m0 in this frame.
   typedef struct packed {
      logic       pa;
      logic       pm;
      logic [5:0] s0;
      logic [5:0] s1;
      logic [5:0] m0;
      logic       lit_a;
      logic       lit_b;
      logic [6:0] e0;
      logic [6:0] e1;
      logic [6:0] e2;
   } vec_t;

   localparam int NV = 13;
   vec_t tbl [NV];

   task automatic cmp(input string name, input logic [2:0] ea, input logic [6:0] es,
                      input logic ed);
      checks++;
      if (an !== ea || seg !== es || dp !== ed) begin
         errors++;
         $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                  name, an, seg, dp, ea, es, ed);
      end
   endtask

   // j = output position within the frame: slot j/4, prescaler j%4.
   task automatic check_cycle(input int f, input int j, input logic lit,
                              input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2);
      logic [2:0] ea;
      logic [6:0] es;
      logic       ed;
      int         sl;
      sl = j / 4;
      ea = 3'b111;
      es = 7'h7F;
      ed = 1'b1;
      if (lit && (j % 4) != 0) begin
         ea[sl] = 1'b0;
         es = (sl == 0) ? e0 : ((sl == 1) ? e1 : e2);
         ed = (sl == 2) ? 1'b0 : 1'b1;
      end
      cmp($sformatf("frame%0d_cyc%0d", f, j), ea, es, ed);
   endtask

   // Every cycle: at most one anode low, and no direct hand-over between two lit slots.
   always @(negedge clk) begin
      inv_checks <= inv_checks + 1;
      if (($countones(~an) > 1) ||
          (an != 3'b111 && prev_an != 3'b111 && an != prev_an)) begin
         inv_errors <= inv_errors + 1;
         $display("FAIL anode_exclusive: got an=%b after an=%b, required one-hot-low with blank between slots",
                  an, prev_an);
      end
      prev_an <= an;
   end

   initial begin
      checks     = 0;
      errors     = 0;
      inv_checks = 0;
      inv_errors = 0;
      prev_an    = 3'b111;

      //          pa    pm    s0     s1     m0    la    lb    e0     e1     e2
      tbl[0]  = '{1'b0, 1'b0, 6'd3,  6'd4,  6'd1, 1'b1, 1'b1, 7'h40, 7'h40, 7'h40};
      tbl[1]  = '{1'b0, 1'b0, 6'd3,  6'd4,  6'd1, 1'b1, 1'b1, 7'h30, 7'h19, 7'h79};
      tbl[2]  = '{1'b0, 1'b0, 6'd7,  6'd4,  6'd1, 1'b1, 1'b1, 7'h30, 7'h19, 7'h79};
      tbl[3]  = '{1'b0, 1'b0, 6'd12, 6'd18, 6'd9, 1'b1, 1'b1, 7'h78, 7'h19, 7'h79};
      tbl[4]  = '{1'b0, 1'b0, 6'd12, 6'd4,  6'd9, 1'b1, 1'b1, 7'h3F, 7'h3F, 7'h10};
      tbl[5]  = '{1'b1, 1'b1, 6'd5,  6'd0,  6'd2, 1'b1, 1'b1, 7'h3F, 7'h19, 7'h10};
      tbl[6]  = '{1'b1, 1'b1, 6'd5,  6'd0,  6'd2, 1'b1, 1'b1, 7'h12, 7'h40, 7'h24};
      tbl[7]  = '{1'b1, 1'b1, 6'd8,  6'd9,  6'd6, 1'b0, 1'b0, 7'h12, 7'h40, 7'h24};
      tbl[8]  = '{1'b1, 1'b1, 6'd8,  6'd9,  6'd6, 1'b0, 1'b0, 7'h00, 7'h10, 7'h02};
      tbl[9]  = '{1'b1, 1'b1, 6'd8,  6'd9,  6'd6, 1'b1, 1'b1, 7'h00, 7'h10, 7'h02};
      tbl[10] = '{1'b1, 1'b1, 6'd8,  6'd9,  6'd6, 1'b1, 1'b1, 7'h00, 7'h10, 7'h02};
      tbl[11] = '{1'b1, 1'b0, 6'd8,  6'd9,  6'd6, 1'b0, 1'b1, 7'h00, 7'h10, 7'h02};
      tbl[12] = '{1'b0, 1'b0, 6'd8,  6'd9,  6'd6, 1'b1, 1'b1, 7'h00, 7'h10, 7'h02};

      reset    = 1'b1;
      paused   = 1'b0;
      seconds0 = 6'd0;
      seconds1 = 6'd0;
      minutes0 = 6'd0;
      repeat (3) @(posedge clk);
      #2;
      cmp("reset_state", 3'b111, 7'h7F, 1'b1);

      reset    = 1'b0;
      seconds0 = 6'd3;
      seconds1 = 6'd4;
      minutes0 = 6'd1;

      for (int f = 0; f < NV; f++) begin
         paused = tbl[f].pa;
         for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            #2;
            check_cycle(f, j, (j <= 5) ? tbl[f].lit_a : tbl[f].lit_b,
                        tbl[f].e0, tbl[f].e1, tbl[f].e2);
            if (j == 5) begin
               seconds0 = tbl[f].s0;
               seconds1 = tbl[f].s1;
               minutes0 = tbl[f].m0;
               paused   = tbl[f].pm;
            end
         end
      end

      // Reset asserted in slot 1 with p=2: outputs must blank without waiting for a clock.
      for (int j = 0; j < 6; j++) begin
         @(posedge clk);
         #2;
         check_cycle(NV, j, 1'b1, 7'h00, 7'h10, 7'h02);
      end
      #1 reset = 1'b1;
      #1 cmp("reset_async", 3'b111, 7'h7F, 1'b1);
      repeat (2) @(posedge clk);
      #2;
      cmp("reset_held", 3'b111, 7'h7F, 1'b1);
      reset = 1'b0;

      // After release the scan restarts at slot 0, p=0 with zeroed shadows.
      for (int j = 0; j < 12; j++) begin
         @(posedge clk);
         #2;
         check_cycle(NV + 1, j, 1'b1, 7'h40, 7'h40, 7'h40);
      end

      @(posedge clk);
      #2;
      checks = checks + inv_checks;
      errors = errors + inv_errors;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
